mem_arb_ctrl: RTL

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

---
 rtl/mem_arb_ctrl_pkg.sv | 20 ++
 rtl/mem_arb_ctrl_wd.sv | 30 +++
 rtl/mem_arb_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_ctrl_pkg.sv
// Shared definitions for the fetch/data memory arbiter: state encoding,
// watchdog default and address-alignment helper.
package mem_arb_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DATA_WAIT  = 3'd1,
    FETCH_WAIT = 3'd2,
    HALTED     = 3'd3,
    ERROR      = 3'd4
  } arb_state_e;

  localparam int TIMEOUT_DEF = 15;

  // Word accesses must be even-aligned; bit0 set marks a bad address.
  function automatic logic addr_odd(input logic [15:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/mem_arb_ctrl_wd.sv
// Watchdog for an outstanding memory access: counts enabled cycles and
// flags the cycle on which the count limit is reached.
module wd_counter
  import mem_arb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [3:0] TC_VAL = 4'(TIMEOUT - 1);

  logic [3:0] count_r;

  assign tc = enable && (count_r == TC_VAL);

  // Wait-cycle counter, saturating at the terminal value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_r <= 4'd0;
    end else if (enable && !tc) begin
      count_r <= count_r + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Single-port memory arbiter between instruction fetch and data accesses,
// with one outstanding access, halt handling and a sticky fault state.
module mem_arb_ctrl
  import mem_arb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  input  logic        halt,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        if_valid,
  output logic [15:0] if_data,
  output logic        dm_valid,
  output logic [15:0] dm_rdata,
  output logic        cpu_stall,
  output logic        err
);

  arb_state_e state_r, state_n;
  logic       store_r, store_n;
  logic       err_r;
  logic       issue_s;
  logic       wd_en_s;
  logic       wd_tc_s;

  assign wd_en_s = ((state_r == DATA_WAIT) || (state_r == FETCH_WAIT)) && !mem_done;
  assign err     = err_r;

  wd_counter #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (issue_s),
    .enable (wd_en_s),
    .tc     (wd_tc_s)
  );

  // Next-state and output decode.
  always_comb begin
    state_n   = state_r;
    store_n   = store_r;
    issue_s   = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    if_valid  = 1'b0;
    if_data   = 16'h0000;
    dm_valid  = 1'b0;
    dm_rdata  = 16'h0000;
    cpu_stall = 1'b0;
    case (state_r)
      IDLE: begin
        if (dm_rd && dm_wr) begin
          state_n = ERROR;
        end else if (halt && !(dm_rd || dm_wr)) begin
          state_n = HALTED;
        end else if (mem_busy) begin
          state_n = IDLE;
        end else if (dm_rd || dm_wr) begin
          if (addr_odd(dm_addr)) begin
            state_n = ERROR;
          end else begin
            issue_s   = 1'b1;
            mem_en    = 1'b1;
            mem_wr    = dm_wr;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            store_n   = dm_wr;
            state_n   = DATA_WAIT;
          end
        end else if (if_req) begin
          if (addr_odd(if_addr)) begin
            state_n = ERROR;
          end else begin
            issue_s  = 1'b1;
            mem_en   = 1'b1;
            mem_addr = if_addr;
            state_n  = FETCH_WAIT;
          end
        end else begin
          state_n = IDLE;
        end
      end
      DATA_WAIT: begin
        if (mem_done) begin
          dm_valid = 1'b1;
          dm_rdata = store_r ? 16'h0000 : mem_rdata;
          state_n  = IDLE;
        end else if (wd_tc_s) begin
          state_n = ERROR;
        end else begin
          state_n = DATA_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (mem_done) begin
          if_valid = 1'b1;
          if_data  = mem_rdata;
          state_n  = IDLE;
        end else if (wd_tc_s) begin
          state_n = ERROR;
        end else begin
          state_n = FETCH_WAIT;
        end
      end
      HALTED:  state_n = HALTED;
      ERROR:   state_n = ERROR;
      default: state_n = ERROR;
    endcase
    if ((state_r == HALTED) || (state_r == ERROR)) begin
      cpu_stall = 1'b1;
    end else begin
      cpu_stall = (if_req || dm_rd || dm_wr) && !(if_valid || dm_valid);
    end
  end

  // State, store flag and sticky fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      store_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      store_r <= store_n;
      if (state_n == ERROR) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule
